// File: rtl/calc_pkg.sv
// Shared definitions for the calculator op sequencer.
//   - opcode constants driven on the result-mux select
//   - FSM state encoding
//   - latency counter width
package calc_pkg;

  localparam int CNT_W = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } state_t;

endpackage

// File: rtl/calc_lat_counter.sv
// Loadable down-counter that times the wait for an arithmetic unit.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val (takes priority over dec)
//   load_val    initial count, the opcode's latency in cycles
//   dec         decrement by one, saturating at zero
//   done        count is 1: the unit output is valid during this cycle
module calc_lat_counter
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Loaded with LAT and decremented from the launch cycle on, so the count
  // reads 1 in the last cycle before the result must be captured.
  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/calc_op_sequencer.sv
// Control and result stage around the calculator datapath. Accepts one
// command, drives operands and the result-mux select, pulses start, waits
// the opcode latency, captures mux_y and offers it on a valid/ready port.
// An accumulator holds the last captured result for chained commands.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op, cmd_a, cmd_b       opcode and operands
//   cmd_use_acc                use the accumulator in place of cmd_a
//   acc_clear                  synchronous accumulator clear
//   opa, opb, sel, start       operands, mux select, launch pulse to units
//   mux_y                      result-mux output from the datapath
//   res_valid/res_ready        result handshake, res_data the result
//   busy                       sequencer not idle
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int W       = 16,
  parameter int LAT_ADD = 1,
  parameter int LAT_SUB = 1,
  parameter int LAT_MUL = 4,
  parameter int LAT_DIV = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  input  logic         acc_clear,
  output logic [W-1:0] opa,
  output logic [W-1:0] opb,
  output logic [1:0]   sel,
  output logic         start,
  input  logic [W-1:0] mux_y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         busy
);

  if (LAT_ADD < 1 || LAT_ADD > 255 || LAT_SUB < 1 || LAT_SUB > 255 ||
      LAT_MUL < 1 || LAT_MUL > 255 || LAT_DIV < 1 || LAT_DIV > 255) begin : g_lat_range
    $error("calc_op_sequencer: every LAT_* parameter must lie in 1..255");
  end

  function automatic logic [CNT_W-1:0] lat_for(input logic [1:0] op);
    case (op)
      OP_ADD:  lat_for = CNT_W'(LAT_ADD);
      OP_SUB:  lat_for = CNT_W'(LAT_SUB);
      OP_MUL:  lat_for = CNT_W'(LAT_MUL);
      default: lat_for = CNT_W'(LAT_DIV);
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] acc_q;
  logic         accept;
  logic         capture;
  logic         counting;
  logic         cnt_done;

  calc_lat_counter u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (lat_for(cmd_op)),
    .dec      (counting),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    counting  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Held low while reset is asserted so nothing is offered until release.
        cmd_ready = rst_n;
        busy      = 1'b0;
        if (cmd_valid && rst_n) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        start    = 1'b1;
        counting = 1'b1;
        state_d  = cnt_done ? ST_HOLD : ST_WAIT;
      end
      ST_WAIT: begin
        counting = 1'b1;
        if (cnt_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept  = cmd_valid && cmd_ready;
  assign capture = counting && cnt_done;

  // Operands and select stay frozen from accept until the next accept, so
  // the units see stable inputs for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa <= '0;
      opb <= '0;
      sel <= OP_ADD;
    end else if (accept) begin
      opa <= cmd_use_acc ? acc_q : cmd_a;
      opb <= cmd_b;
      sel <= cmd_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if (capture) begin
      res_data <= mux_y;
    end
  end

  // A clear on the capture edge wins for the accumulator only; res_data
  // still records the unit's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_clear) begin
      acc_q <= '0;
    end else if (capture) begin
      acc_q <= mux_y;
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer with behavioural arithmetic
// units and a 4:1 result mux on the datapath side.
module tb_calc_op_sequencer;

  localparam int W       = 16;
  localparam int LAT_ADD = 1;
  localparam int LAT_SUB = 1;
  localparam int LAT_MUL = 4;
  localparam int LAT_DIV = 17;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_use_acc = 1'b0;
  logic         acc_clear = 1'b0;
  logic [W-1:0] opa, opb;
  logic [1:0]   sel;
  logic         start;
  logic [W-1:0] mux_y;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_data;
  logic         busy;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] model_acc = '0;

  always #5 clk = ~clk;

  calc_op_sequencer #(
    .W(W), .LAT_ADD(LAT_ADD), .LAT_SUB(LAT_SUB), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clear(acc_clear),
    .opa(opa), .opb(opb), .sel(sel), .start(start), .mux_y(mux_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  // ---------------- reference rules ----------------
  function automatic int ref_lat(input logic [1:0] op);
    case (op)
      2'b00:   return LAT_ADD;
      2'b01:   return LAT_SUB;
      2'b10:   return LAT_MUL;
      default: return LAT_DIV;
    endcase
  endfunction

  function automatic logic [W-1:0] ref_calc(input logic [1:0] op, input logic [W-1:0] a, b);
    logic [31:0] p;
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin p = {16'd0, a} * {16'd0, b}; return p[15:0]; end
      default: return (b == 0) ? 16'hFFFF : a / b;
    endcase
  endfunction

  // ---------------- datapath: units + result mux ----------------
  // Each unit output is only correct once its latency has elapsed since
  // start; before that the mux shows the inverted value.
  logic [W-1:0] d0, d1, d2, d3, y_raw;
  int           age = 255;
  int           cur_age;
  assign d0 = opa + opb;
  assign d1 = opa - opb;
  assign d2 = 16'(opa * opb);
  assign d3 = (opb == '0) ? 16'hFFFF : opa / opb;

  always @(posedge clk) begin
    if (start) age <= 1;
    else if (age < 255) age <= age + 1;
  end

  always_comb begin
    case (sel)
      2'b00:   y_raw = d0;
      2'b01:   y_raw = d1;
      2'b10:   y_raw = d2;
      default: y_raw = d3;
    endcase
    cur_age = start ? 0 : age;
    mux_y   = (cur_age >= ref_lat(sel) - 1) ? y_raw : ~y_raw;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] a, b,
                          input logic ua, input logic clr, output bit ok);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua; cmd_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        acc_clear = clr;
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; acc_clear = 1'b0;
  endtask

  // Entered just after the accept edge; edges counts that edge as 1.
  task automatic wait_result(input int lat, input bit clr_cap,
                             output int edges, output int starts, output bit ok);
    edges = 1; starts = 0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (start) starts++;
      if (res_valid) begin ok = 1'b1; break; end
      acc_clear = clr_cap && (edges == lat);
      @(posedge clk); #1;
      edges++;
    end
    acc_clear = 1'b0;
  endtask

  task automatic take_result(input int delay);
    for (int i = 0; i < delay; i++) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({cmd_ready, res_valid, start, busy} !== 4'b1000) begin
      $display("FAIL reset_ctrl: {ready,valid,start,busy} got %b expected 1000",
               {cmd_ready, res_valid, start, busy});
      n_fail++;
    end
    n_checks++;
    if (res_data !== 16'd0) begin $display("FAIL reset_res_data: got %0d expected 0", res_data); n_fail++; end
    n_checks++;
    if ({opa, opb, sel} !== 34'd0) begin
      $display("FAIL reset_operands: opa %0d opb %0d sel %0d expected all 0", opa, opb, sel); n_fail++;
    end
    model_acc = '0;
  endtask

  task automatic test_add();
    bit ok; int edges, starts;
    res_ready = 1'b1;
    send_cmd(2'b00, 16'd10, 16'd20, 1'b0, 1'b0, ok);
    n_checks++;
    if (!ok) begin $display("FAIL add_accept: not accepted within budget"); n_fail++; end
    wait_result(LAT_ADD, 1'b0, edges, starts, ok);
    n_checks++;
    if (!ok) begin $display("FAIL add_valid: no res_valid within budget"); n_fail++; end
    n_checks++;
    if (starts !== 1) begin $display("FAIL add_start_pulse: got %0d cycles expected 1", starts); n_fail++; end
    n_checks++;
    if (edges !== 2) begin $display("FAIL add_latency: got %0d edges expected 2", edges); n_fail++; end
    n_checks++;
    if (res_data !== 16'd30) begin $display("FAIL add_result: got %0d expected 30", res_data); n_fail++; end
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++;
    if ({res_valid, cmd_ready} !== 2'b01) begin
      $display("FAIL add_one_cycle_valid: {valid,ready} got %b expected 01", {res_valid, cmd_ready}); n_fail++;
    end
    model_acc = 16'd30;
  endtask

  task automatic test_mul_holdoff();
    bit ok; int edges, starts;
    res_ready = 1'b0;
    send_cmd(2'b10, 16'd6, 16'd7, 1'b0, 1'b0, ok);
    n_checks++;
    if (!ok) begin $display("FAIL mul_accept: not accepted within budget"); n_fail++; end
    // Second command offered while busy; it must wait.
    cmd_op = 2'b00; cmd_a = 16'd1; cmd_b = 16'd2; cmd_use_acc = 1'b0; cmd_valid = 1'b1;
    wait_result(LAT_MUL, 1'b0, edges, starts, ok);
    n_checks++;
    if (edges !== LAT_MUL + 1) begin $display("FAIL mul_latency: got %0d edges expected %0d", edges, LAT_MUL + 1); n_fail++; end
    n_checks++;
    if (res_data !== 16'd42) begin $display("FAIL mul_result: got %0d expected 42", res_data); n_fail++; end
    @(posedge clk); #1;
    n_checks++;
    if ({cmd_ready, res_valid, opa, opb, sel} !== {1'b0, 1'b1, 16'd6, 16'd7, 2'b10}) begin
      $display("FAIL mul_holdoff: ready %b valid %b opa %0d opb %0d sel %0d expected 0 1 6 7 2",
               cmd_ready, res_valid, opa, opb, sel); n_fail++;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++;
    if ({cmd_ready, res_valid, start} !== 3'b100) begin
      $display("FAIL mul_after_handshake: {ready,valid,start} got %b expected 100", {cmd_ready, res_valid, start}); n_fail++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++;
    if ({start, opa, opb, sel} !== {1'b1, 16'd1, 16'd2, 2'b00}) begin
      $display("FAIL mul_second_accept: start %b opa %0d opb %0d sel %0d expected 1 1 2 0",
               start, opa, opb, sel); n_fail++;
    end
    wait_result(LAT_ADD, 1'b0, edges, starts, ok);
    n_checks++;
    if (res_data !== 16'd3) begin $display("FAIL mul_second_result: got %0d expected 3", res_data); n_fail++; end
    take_result(0);
    model_acc = 16'd3;
  endtask

  task automatic test_backpressure();
    bit ok; int edges, starts;
    logic [1:0] op; logic [W-1:0] a, b, exp;
    op = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom);
    exp = ref_calc(op, a, b);
    res_ready = 1'b0;
    send_cmd(op, a, b, 1'b0, 1'b0, ok);
    wait_result(ref_lat(op), 1'b0, edges, starts, ok);
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) res_ready = 1'b1;
      n_checks++;
      if ({res_valid, res_data} !== {1'b1, exp}) begin
        $display("FAIL bp_hold_cycle%0d: valid %b data %h expected 1 %h", c, res_valid, res_data, exp); n_fail++;
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b0;
    n_checks++;
    if ({cmd_ready, res_valid} !== 2'b10) begin
      $display("FAIL bp_release: {ready,valid} got %b expected 10", {cmd_ready, res_valid}); n_fail++;
    end
    model_acc = exp;
  endtask

  task automatic test_chain();
    bit ok; int edges, starts;
    acc_clear = 1'b1; @(posedge clk); #1; acc_clear = 1'b0;
    model_acc = '0;
    send_cmd(2'b00, 16'd5, 16'd5, 1'b0, 1'b0, ok);
    wait_result(LAT_ADD, 1'b0, edges, starts, ok);
    n_checks++;
    if (res_data !== 16'd10) begin $display("FAIL chain_add: got %0d expected 10", res_data); n_fail++; end
    take_result(1);
    send_cmd(2'b01, 16'hBEEF, 16'd3, 1'b1, 1'b0, ok);
    n_checks++;
    if (opa !== 16'd10) begin $display("FAIL chain_opa: got %0d expected 10", opa); n_fail++; end
    wait_result(LAT_SUB, 1'b0, edges, starts, ok);
    n_checks++;
    if (res_data !== 16'd7) begin $display("FAIL chain_sub: got %0d expected 7", res_data); n_fail++; end
    take_result(0);
    send_cmd(2'b00, 16'd1234, 16'd0, 1'b1, 1'b0, ok);
    n_checks++;
    if (opa !== 16'd7) begin $display("FAIL chain_acc: got %0d expected 7", opa); n_fail++; end
    wait_result(LAT_ADD, 1'b0, edges, starts, ok);
    take_result(0);
    model_acc = 16'd7;
  endtask

  task automatic test_reset_mid_wait();
    bit ok, saw_valid; int edges, starts;
    send_cmd(2'b11, 16'd100, 16'd7, 1'b0, 1'b0, ok);
    repeat (5) begin @(posedge clk); #1; end
    n_checks++;
    if (busy !== 1'b1) begin $display("FAIL rst_busy_before: got %b expected 1", busy); n_fail++; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cmd_ready, res_valid, start, busy, res_data, opa, opb, sel} !== 54'd0) begin
      $display("FAIL rst_async: ready %b valid %b start %b busy %b data %0d opa %0d opb %0d sel %0d expected all 0",
               cmd_ready, res_valid, start, busy, res_data, opa, opb, sel); n_fail++;
    end
    @(negedge clk) rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (res_valid) saw_valid = 1'b1; end
    n_checks++;
    if (saw_valid) begin $display("FAIL rst_no_result: res_valid seen after reset, expected none"); n_fail++; end
    send_cmd(2'b00, 16'd999, 16'd0, 1'b1, 1'b0, ok);
    n_checks++;
    if (opa !== 16'd0) begin $display("FAIL rst_acc_zero: acc got %0d expected 0", opa); n_fail++; end
    wait_result(LAT_ADD, 1'b0, edges, starts, ok);
    take_result(0);
    model_acc = '0;
  endtask

  task automatic test_clear_on_capture();
    bit ok; int edges, starts;
    send_cmd(2'b00, 16'd3, 16'd4, 1'b0, 1'b0, ok);
    wait_result(LAT_ADD, 1'b0, edges, starts, ok);
    take_result(0);
    // Clear on the accept edge: the operand still takes the pre-edge acc.
    send_cmd(2'b00, 16'd0, 16'd0, 1'b1, 1'b1, ok);
    n_checks++;
    if (opa !== 16'd7) begin $display("FAIL clr_accept_pre_edge: opa got %0d expected 7", opa); n_fail++; end
    wait_result(LAT_ADD, 1'b0, edges, starts, ok);
    take_result(0);
    send_cmd(2'b00, 16'd40, 16'd0, 1'b0, 1'b0, ok);
    wait_result(LAT_ADD, 1'b1, edges, starts, ok);
    n_checks++;
    if (res_data !== 16'd40) begin $display("FAIL clr_capture_data: got %0d expected 40", res_data); n_fail++; end
    take_result(0);
    send_cmd(2'b00, 16'd55, 16'd0, 1'b1, 1'b0, ok);
    n_checks++;
    if (opa !== 16'd0) begin $display("FAIL clr_capture_acc: acc got %0d expected 0", opa); n_fail++; end
    wait_result(LAT_ADD, 1'b0, edges, starts, ok);
    take_result(0);
    model_acc = '0;
  endtask

  task automatic test_random();
    bit ok; int edges, starts, lat;
    logic [1:0] op; logic [W-1:0] a, b, exp_opa, exp;
    bit ua, clr_acc, clr_cap, rdy_early;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      ua = 1'($urandom_range(0, 1));
      clr_acc = ($urandom_range(0, 4) == 0);
      clr_cap = ($urandom_range(0, 4) == 0);
      rdy_early = 1'($urandom_range(0, 1));
      lat = ref_lat(op);
      exp_opa = ua ? model_acc : a;
      exp = ref_calc(op, exp_opa, b);
      res_ready = rdy_early;
      send_cmd(op, a, b, ua, clr_acc, ok);
      n_checks++;
      if (!ok || {opa, opb, sel} !== {exp_opa, b, op}) begin
        $display("FAIL rand%0d_issue: ok %b opa %h opb %h sel %0d expected opa %h opb %h sel %0d",
                 n, ok, opa, opb, sel, exp_opa, b, op); n_fail++;
      end
      wait_result(lat, clr_cap, edges, starts, ok);
      n_checks++;
      if (!ok || edges != lat + 1 || starts != 1) begin
        $display("FAIL rand%0d_timing: ok %b edges %0d starts %0d expected edges %0d starts 1",
                 n, ok, edges, starts, lat + 1); n_fail++;
      end
      n_checks++;
      if (res_data !== exp) begin
        $display("FAIL rand%0d_result: op %0d got %h expected %h", n, op, res_data, exp); n_fail++;
      end
      model_acc = clr_cap ? '0 : exp;
      if (rdy_early) begin
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_checks++;
        if ({res_valid, cmd_ready} !== 2'b01) begin
          $display("FAIL rand%0d_one_cycle: {valid,ready} got %b expected 01", n, {res_valid, cmd_ready}); n_fail++;
        end
      end else begin
        take_result($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_mul_holdoff();
    test_backpressure();
    test_chain();
    test_reset_mid_wait();
    test_clear_on_capture();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
